// File: rtl/bg_pkg.sv
// Shared definitions for the background-removal controller and PE array.
// The one-hot state encoding is common to bg_ctrl and pe.
package bg_pkg;

   localparam int unsigned PIX_W = 8;
   localparam int unsigned ST_W  = 9;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE     = 9'b000000001,
      ST_SUM_GO   = 9'b000000010,
      ST_SUM_WAIT = 9'b000000100,
      ST_ACCUM    = 9'b000001000,
      ST_SUM_ACK  = 9'b000010000,
      ST_BG_GO    = 9'b000100000,
      ST_BG_WAIT  = 9'b001000000,
      ST_BG_ACK   = 9'b010000000,
      ST_FIN      = 9'b100000000
   } state_t;

   // Clamp an unsigned quotient to the 8-bit pixel range.
   function automatic logic [PIX_W-1:0] sat8(input logic [31:0] v);
      return (v > 32'd255) ? PIX_W'(255) : PIX_W'(v);
   endfunction

endpackage

// File: rtl/bg_avg_accum.sv
// Serial per-channel colour accumulator with shift divide and saturation.
// The result register only moves on add cycles, so it holds between passes.
module bg_avg_accum
   import bg_pkg::*;
#(
   parameter int unsigned SUM_W    = 16,
   parameter int unsigned NUM_PE   = 4,
   parameter int unsigned LOG2_PIX = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             add,
   input  logic [SUM_W-1:0] sum,
   output logic [PIX_W-1:0] result
);

   localparam int unsigned ACC_W = SUM_W + $clog2(NUM_PE);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;

   assign acc_nxt = acc + ACC_W'(sum);

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         result <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (add) begin
         acc    <= acc_nxt;
         result <= sat8(32'(acc_nxt >> LOG2_PIX));
      end
   end

endmodule

// File: rtl/bg_ctrl.sv
// Sequencer for one background-removal pass over the PE array:
// sum phase, serial averaging, then bg-removal phase, with PE handshakes.
module bg_ctrl
   import bg_pkg::*;
#(
   parameter int unsigned NUM_PE   = 4,
   parameter int unsigned SUM_W    = 16,
   parameter int unsigned LOG2_PIX = 4,
   parameter int unsigned THR_W    = 18
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Start,
   input  logic [THR_W-1:0]        thresh_in,
   input  logic [7:0]              bg_r_in,
   input  logic [7:0]              bg_g_in,
   input  logic [7:0]              bg_b_in,
   input  logic [NUM_PE-1:0]       Qi_vec,
   input  logic [NUM_PE-1:0]       Qsd_vec,
   input  logic [NUM_PE-1:0]       Qbgd_vec,
   input  logic [NUM_PE*SUM_W-1:0] red_sum_vec,
   input  logic [NUM_PE*SUM_W-1:0] green_sum_vec,
   input  logic [NUM_PE*SUM_W-1:0] blue_sum_vec,
   output logic                    Start_Sum,
   output logic                    Start_BgRemoval,
   output logic                    Ack,
   output logic [7:0]              red_exp,
   output logic [7:0]              green_exp,
   output logic [7:0]              blue_exp,
   output logic [THR_W-1:0]        threshold,
   output logic [7:0]              desired_bg_r,
   output logic [7:0]              desired_bg_g,
   output logic [7:0]              desired_bg_b,
   output logic                    Busy,
   output logic                    Done
);

   localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_PE - 1);

   state_t           state;
   logic [IDX_W-1:0] k;
   logic             acc_clr;
   logic             acc_add;

   assign acc_clr = (state == ST_IDLE) && Start;
   assign acc_add = (state == ST_ACCUM);

   bg_avg_accum #(.SUM_W(SUM_W), .NUM_PE(NUM_PE), .LOG2_PIX(LOG2_PIX)) u_acc_r (
      .clk(Clk), .reset(Reset), .clear(acc_clr), .add(acc_add),
      .sum(red_sum_vec[32'(k) * SUM_W +: SUM_W]), .result(red_exp));

   bg_avg_accum #(.SUM_W(SUM_W), .NUM_PE(NUM_PE), .LOG2_PIX(LOG2_PIX)) u_acc_g (
      .clk(Clk), .reset(Reset), .clear(acc_clr), .add(acc_add),
      .sum(green_sum_vec[32'(k) * SUM_W +: SUM_W]), .result(green_exp));

   bg_avg_accum #(.SUM_W(SUM_W), .NUM_PE(NUM_PE), .LOG2_PIX(LOG2_PIX)) u_acc_b (
      .clk(Clk), .reset(Reset), .clear(acc_clr), .add(acc_add),
      .sum(blue_sum_vec[32'(k) * SUM_W +: SUM_W]), .result(blue_exp));

   // Strobes default low each cycle; each state raises what it owns for the next cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state           <= ST_IDLE;
         k               <= '0;
         Start_Sum       <= 1'b0;
         Start_BgRemoval <= 1'b0;
         Ack             <= 1'b0;
         Busy            <= 1'b0;
         Done            <= 1'b0;
         threshold       <= '0;
         desired_bg_r    <= '0;
         desired_bg_g    <= '0;
         desired_bg_b    <= '0;
      end else begin
         Start_Sum       <= 1'b0;
         Start_BgRemoval <= 1'b0;
         Ack             <= 1'b0;
         Done            <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (Start) begin
                  threshold    <= thresh_in;
                  desired_bg_r <= bg_r_in;
                  desired_bg_g <= bg_g_in;
                  desired_bg_b <= bg_b_in;
                  Start_Sum    <= 1'b1;
                  Busy         <= 1'b1;
                  state        <= ST_SUM_GO;
               end
            end
            ST_SUM_GO: state <= ST_SUM_WAIT;
            ST_SUM_WAIT: begin
               if (&Qsd_vec) begin
                  k     <= '0;
                  state <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (k == LAST_K) begin
                  Ack   <= 1'b1;
                  state <= ST_SUM_ACK;
               end else begin
                  k <= k + IDX_W'(1);
               end
            end
            ST_SUM_ACK: begin
               if (&Qi_vec) begin
                  Start_BgRemoval <= 1'b1;
                  state           <= ST_BG_GO;
               end else begin
                  Ack <= 1'b1;
               end
            end
            ST_BG_GO: state <= ST_BG_WAIT;
            ST_BG_WAIT: begin
               if (&Qbgd_vec) begin
                  Ack   <= 1'b1;
                  state <= ST_BG_ACK;
               end
            end
            ST_BG_ACK: begin
               if (&Qi_vec) begin
                  Done  <= 1'b1;
                  state <= ST_FIN;
               end else begin
                  Ack <= 1'b1;
               end
            end
            ST_FIN: begin
               Busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bg_ctrl.sv
// Scoreboard bench for bg_ctrl: a behavioural PE array answers the handshake,
// expected colours are queued at Start and checked when the DUT presents them.
module tb_bg_ctrl;

   localparam int unsigned NUM_PE   = 4;
   localparam int unsigned SUM_W    = 16;
   localparam int unsigned LOG2_PIX = 4;
   localparam int unsigned THR_W    = 18;
   localparam logic [NUM_PE-1:0] ALL = '1;

   logic                    Clk = 1'b0;
   logic                    Reset = 1'b1;
   logic                    Start = 1'b0;
   logic [THR_W-1:0]        thresh_in = '0;
   logic [7:0]              bg_r_in = '0, bg_g_in = '0, bg_b_in = '0;
   logic [NUM_PE-1:0]       Qi_vec = ALL, Qsd_vec = '0, Qbgd_vec = '0;
   logic [NUM_PE*SUM_W-1:0] red_sum_vec = '0, green_sum_vec = '0, blue_sum_vec = '0;
   logic                    Start_Sum, Start_BgRemoval, Ack, Busy, Done;
   logic [7:0]              red_exp, green_exp, blue_exp;
   logic [THR_W-1:0]        threshold;
   logic [7:0]              desired_bg_r, desired_bg_g, desired_bg_b;

   bg_ctrl #(.NUM_PE(NUM_PE), .SUM_W(SUM_W), .LOG2_PIX(LOG2_PIX), .THR_W(THR_W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .thresh_in(thresh_in),
      .bg_r_in(bg_r_in), .bg_g_in(bg_g_in), .bg_b_in(bg_b_in),
      .Qi_vec(Qi_vec), .Qsd_vec(Qsd_vec), .Qbgd_vec(Qbgd_vec),
      .red_sum_vec(red_sum_vec), .green_sum_vec(green_sum_vec), .blue_sum_vec(blue_sum_vec),
      .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
      .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
      .threshold(threshold), .desired_bg_r(desired_bg_r), .desired_bg_g(desired_bg_g),
      .desired_bg_b(desired_bg_b), .Busy(Busy), .Done(Done));

   always #5 Clk = ~Clk;

   typedef struct {
      int r, g, b, br, bgc, bb, th;
   } exp_t;

   exp_t exp_q[$];
   int   lat_q[$];

   int unsigned rs[NUM_PE], gs[NUM_PE], bs[NUM_PE];
   int   sum_dly = 0, ack_dly = 0, bg_dly = 0;
   int   cyc = 0;
   logic rst_q = 1'b0;

   // Handshake bookkeeping from the PE model, read by the monitor.
   int   sd_full_cyc = 0, bd_full_cyc = 0, qi_cyc = 0;

   int   n_checks = 0, n_pass = 0;
   int   done_cnt = 0, exp_passes = 0, last_done_cyc = 0;
   bit   hold_mode = 1'b0, timed_out = 1'b0, end_req = 1'b0;

   always @(posedge Clk) begin
      cyc   <= cyc + 1;
      rst_q <= Reset;
   end

   function automatic int ref_avg(input int ch);
      longint t = 0;
      for (int i = 0; i < NUM_PE; i++)
         t += (ch == 0) ? longint'(rs[i]) : (ch == 1) ? longint'(gs[i]) : longint'(bs[i]);
      t = t >> LOG2_PIX;
      return (t > 255) ? 255 : int'(t);
   endfunction

   function automatic logic [NUM_PE-1:0] partial_flags();
      logic [NUM_PE-1:0] p;
      p = NUM_PE'($urandom);
      p = p & ~(NUM_PE'(1) << $urandom_range(0, NUM_PE - 1));
      return p;
   endfunction

   // Behavioural PE array: responds to strobes with configurable delays.
   typedef enum {P_IDLE, P_SUM, P_SDONE, P_BGW, P_BG, P_BDONE} pst_t;
   initial begin
      pst_t pst = P_IDLE;
      int   cnt = 0, ack_cnt = 0;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            pst = P_IDLE; Qi_vec = ALL; Qsd_vec = '0; Qbgd_vec = '0;
         end else begin
            case (pst)
               P_IDLE: if (Start_Sum) begin
                  Qi_vec = '0; ack_cnt = 0;
                  if (sum_dly == 0) begin Qsd_vec = ALL; sd_full_cyc = cyc; pst = P_SDONE; end
                  else begin Qsd_vec = partial_flags(); cnt = sum_dly; pst = P_SUM; end
               end
               P_SUM: begin
                  cnt--;
                  if (cnt == 0) begin Qsd_vec = ALL; sd_full_cyc = cyc; pst = P_SDONE; end
                  else Qsd_vec = partial_flags();
               end
               P_SDONE: if (Ack) begin
                  if (ack_cnt == ack_dly) begin
                     Qsd_vec = '0; Qi_vec = ALL; qi_cyc = cyc; pst = P_BGW;
                  end else ack_cnt++;
               end
               P_BGW: if (Start_BgRemoval) begin
                  Qi_vec = '0; ack_cnt = 0;
                  if (bg_dly == 0) begin Qbgd_vec = ALL; bd_full_cyc = cyc; pst = P_BDONE; end
                  else begin Qbgd_vec = partial_flags(); cnt = bg_dly; pst = P_BG; end
               end
               P_BG: begin
                  cnt--;
                  if (cnt == 0) begin Qbgd_vec = ALL; bd_full_cyc = cyc; pst = P_BDONE; end
                  else Qbgd_vec = partial_flags();
               end
               P_BDONE: if (Ack) begin
                  if (ack_cnt == ack_dly) begin
                     Qbgd_vec = '0; Qi_vec = ALL; qi_cyc = cyc; pst = P_IDLE;
                  end else ack_cnt++;
               end
               default: pst = P_IDLE;
            endcase
         end
      end
   end

   task automatic chk(input string nm, input longint act, input longint expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
   endtask

   // Monitor: pops the scoreboard and checks handshake timing as the DUT presents events.
   bit prev_ack = 1'b0, prev_done = 1'b0, phase_bg = 1'b0, to_rep = 1'b0, end_done = 1'b0;
   int ack_run = 0, n_ss = 0, n_bg = 0, ss_cyc = 0, hold_ss = 0;
   always @(negedge Clk) begin
      exp_t e;
      int   s, l;
      if (rst_q) begin
         chk("rst_strobes", longint'({Start_Sum, Start_BgRemoval, Ack, Busy, Done}), 0);
         chk("rst_exp", longint'({red_exp, green_exp, blue_exp}), 0);
         chk("rst_capture", longint'({threshold, desired_bg_r, desired_bg_g, desired_bg_b}), 0);
         prev_ack = 1'b0; prev_done = 1'b0; phase_bg = 1'b0; ack_run = 0; n_ss = 0; n_bg = 0;
      end else begin
         s = int'(Start_Sum) + int'(Start_BgRemoval) + int'(Ack);
         if (s > 0) chk("strobe_exclusive", longint'(s), 1);
         if (prev_done) chk("busy_idle", longint'(Busy), 0);
         if (Start_Sum) begin
            n_ss++; ss_cyc = cyc; phase_bg = 1'b0;
            chk("busy_at_start_sum", longint'(Busy), 1);
            if (hold_mode) begin
               hold_ss++;
               if (hold_ss == 2) chk("resample_gap", longint'(cyc - last_done_cyc), 2);
            end
         end
         if (Start_BgRemoval) begin
            n_bg++; phase_bg = 1'b1;
            chk("bg_go_after_idle", longint'(cyc - qi_cyc), 1);
         end
         if (Ack && !prev_ack) begin
            if (!phase_bg) begin
               chk("sum_ack_latency", longint'(cyc - sd_full_cyc),
                   longint'(NUM_PE + 1 + int'(sum_dly == 0)));
               if (exp_q.size() == 0) chk("scoreboard_empty", 0, 1);
               else begin
                  e = exp_q.pop_front();
                  chk("red_exp", longint'(red_exp), longint'(e.r));
                  chk("green_exp", longint'(green_exp), longint'(e.g));
                  chk("blue_exp", longint'(blue_exp), longint'(e.b));
                  chk("threshold", longint'(threshold), longint'(e.th));
                  chk("desired_bg", longint'({desired_bg_r, desired_bg_g, desired_bg_b}),
                      (longint'(e.br) << 16) | (longint'(e.bgc) << 8) | longint'(e.bb));
               end
            end else begin
               chk("bg_ack_latency", longint'(cyc - bd_full_cyc),
                   longint'(1 + int'(bg_dly == 0)));
            end
         end
         if (Ack) ack_run++;
         else if (prev_ack) begin
            chk("ack_length", longint'(ack_run), longint'(ack_dly + 1));
            ack_run = 0;
         end
         if (Done) begin
            chk("start_sum_pulses", longint'(n_ss), 1);
            chk("start_bg_pulses", longint'(n_bg), 1);
            chk("done_after_idle", longint'(cyc - qi_cyc), 1);
            chk("busy_at_done", longint'(Busy), 1);
            if (lat_q.size() > 0) begin
               l = lat_q.pop_front();
               if (l >= 0) chk("pass_length", longint'(cyc - ss_cyc), longint'(l));
            end
            n_ss = 0; n_bg = 0; done_cnt++; last_done_cyc = cyc;
         end
         prev_ack  = Ack;
         prev_done = Done;
      end
      if (timed_out && !to_rep) begin chk("timeout", 0, 1); to_rep = 1'b1; end
      if (end_req && !end_done) begin
         chk("pass_count", longint'(done_cnt), longint'(exp_passes));
         chk("scoreboard_left", longint'(exp_q.size()), 0);
         end_done = 1'b1;
      end
   end

   task automatic finish_up();
      end_req = 1'b1;
      repeat (3) @(posedge Clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 2000; i++) begin
         @(posedge Clk);
         if (done_cnt >= target) return;
      end
      timed_out = 1'b1;
      finish_up();
   endtask

   task automatic load_pass(output exp_t e);
      for (int i = 0; i < NUM_PE; i++) begin
         red_sum_vec[i*SUM_W +: SUM_W]   = SUM_W'(rs[i]);
         green_sum_vec[i*SUM_W +: SUM_W] = SUM_W'(gs[i]);
         blue_sum_vec[i*SUM_W +: SUM_W]  = SUM_W'(bs[i]);
      end
      thresh_in = THR_W'($urandom_range(0, 3 * 255 * 255));
      bg_r_in = 8'($urandom); bg_g_in = 8'($urandom); bg_b_in = 8'($urandom);
      e.r = ref_avg(0); e.g = ref_avg(1); e.b = ref_avg(2);
      e.th = int'(thresh_in); e.br = int'(bg_r_in); e.bgc = int'(bg_g_in); e.bb = int'(bg_b_in);
   endtask

   task automatic run_pass(input bit hold, input bit fixed_len);
      exp_t e;
      int   d0;
      int   lat;
      load_pass(e);
      lat = fixed_len ? int'(NUM_PE) + 6 : -1;
      exp_q.push_back(e); lat_q.push_back(lat); exp_passes++;
      if (hold) begin exp_q.push_back(e); lat_q.push_back(lat); exp_passes++; end
      hold_mode = hold; hold_ss = 0;
      d0 = done_cnt;
      Start = 1'b1;
      if (!hold) begin
         @(posedge Clk); #1 Start = 1'b0;
         thresh_in = THR_W'($urandom); bg_r_in = 8'($urandom);
         bg_g_in = 8'($urandom); bg_b_in = 8'($urandom);
         wait_done(d0 + 1);
      end else begin
         wait_done(d0 + 1);
         @(posedge Clk); #1 Start = 1'b0;
         wait_done(d0 + 2);
      end
      #1 hold_mode = 1'b0;
   endtask

   task automatic rand_sums(input bit full);
      for (int i = 0; i < NUM_PE; i++) begin
         rs[i] = full ? $urandom_range(0, 65535) : $urandom_range(0, 1020);
         gs[i] = full ? $urandom_range(0, 65535) : $urandom_range(0, 1020);
         bs[i] = full ? $urandom_range(0, 65535) : $urandom_range(0, 1020);
      end
   endtask

   initial begin
      exp_t e;
      bit   seen;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(posedge Clk); #1;

      for (int i = 0; i < NUM_PE; i++) begin rs[i] = 40; gs[i] = 160; bs[i] = 0; end
      run_pass(1'b0, 1'b1);

      for (int i = 0; i < NUM_PE; i++) begin rs[i] = 'h1000; gs[i] = 'h1000; bs[i] = 'h1000; end
      run_pass(1'b0, 1'b1);

      rand_sums(1'b0); sum_dly = 20;
      run_pass(1'b0, 1'b0);
      sum_dly = 0;

      rand_sums(1'b0); ack_dly = 5;
      run_pass(1'b0, 1'b0);
      ack_dly = 0;

      rand_sums(1'b0);
      run_pass(1'b1, 1'b1);

      // Abort in BG_WAIT: the colour entry is consumed at SUM_ACK, the length entry is dropped.
      rand_sums(1'b0); bg_dly = 10;
      load_pass(e);
      exp_q.push_back(e); lat_q.push_back(-1);
      Start = 1'b1;
      @(posedge Clk); #1 Start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge Clk); #1;
         if (Start_BgRemoval) seen = 1'b1;
      end
      if (!seen) begin timed_out = 1'b1; finish_up(); end
      @(posedge Clk); #1 Reset = 1'b1;
      @(posedge Clk); #1 Reset = 1'b0;
      void'(lat_q.pop_back());
      bg_dly = 0;
      @(posedge Clk); #1;

      rand_sums(1'b0);
      run_pass(1'b0, 1'b1);

      for (int n = 0; n < 20; n++) begin
         rand_sums(($urandom & 3) == 0);
         sum_dly = $urandom_range(0, 6);
         ack_dly = $urandom_range(0, 4);
         bg_dly  = $urandom_range(0, 6);
         run_pass(1'b0, (sum_dly == 0) && (ack_dly == 0) && (bg_dly == 0));
      end

      finish_up();
   end

endmodule
